// File: rtl/dispatch_queue_ctrl.sv
// In-order instruction queue and dispatch scheduler between IFetch and the Decoder.
// Optional performance counters are compiled in with DISPATCH_PERF_EN.
module dispatch_queue_ctrl #(
  parameter int DEPTH_LOG = 4,
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_predict_jump,
  input  logic              if_is_c_extend,
  output logic              iq_full,
  input  logic              rob_full,
  input  logic              rs_full,
  input  logic              lsb_full,
  output logic              dec_inst_valid,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              dec_predict_jump,
  output logic              dec_is_c_extend
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_rob,
  output logic [31:0]       perf_stall_unit,
  output logic [31:0]       perf_issued
`endif
);

  localparam int                   DEPTH      = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   COUNT_FULL = DEPTH[DEPTH_LOG:0];
  localparam logic [DEPTH_LOG:0]   COUNT_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE    = DEPTH_LOG'(1);
  localparam logic [6:0]           OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]           OPC_STORE  = 7'b0100011;

  logic [INST_W-1:0]    inst_mem_r [DEPTH];
  logic [ADDR_W-1:0]    pc_mem_r   [DEPTH];
  logic                 pj_mem_r   [DEPTH];
  logic                 ce_mem_r   [DEPTH];

  logic [DEPTH_LOG-1:0] head_r;
  logic [DEPTH_LOG-1:0] tail_r;
  logic [DEPTH_LOG:0]   count_r;

  logic                 full_s;
  logic                 empty_s;
  logic [6:0]           head_opcode_s;
  logic                 head_is_lsb_s;
  logic                 unit_full_s;
  logic                 issue_s;
  logic                 push_s;

  // Queue status, target-unit selection and the push/issue handshakes.
  always_comb begin
    full_s        = (count_r == COUNT_FULL);
    empty_s       = (count_r == '0);
    head_opcode_s = inst_mem_r[head_r][6:0];
    head_is_lsb_s = (head_opcode_s == OPC_LOAD) || (head_opcode_s == OPC_STORE);
    if (head_is_lsb_s) begin
      unit_full_s = lsb_full;
    end else begin
      unit_full_s = rs_full;
    end
    issue_s = rdy && !rst && !rollback && !empty_s && !rob_full && !unit_full_s;
    push_s  = if_valid && !full_s && rdy && !rollback && !rst;
  end

  // Decoder sees the head slot with zero latency; no bypass from the fetch port.
  assign iq_full          = full_s && !rst;
  assign dec_inst_valid   = issue_s;
  assign dec_inst         = inst_mem_r[head_r];
  assign dec_pc           = pc_mem_r[head_r];
  assign dec_predict_jump = pj_mem_r[head_r];
  assign dec_is_c_extend  = ce_mem_r[head_r];

  // Entry payload storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[tail_r] <= if_inst;
      pc_mem_r[tail_r]   <= if_pc;
      pj_mem_r[tail_r]   <= if_predict_jump;
      ce_mem_r[tail_r]   <= if_is_c_extend;
    end
  end

  // Pointer and occupancy update; reset and rollback both empty the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (rdy) begin
      if (rollback) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (push_s) begin
          tail_r <= tail_r + PTR_ONE;
        end
        if (issue_s) begin
          head_r <= head_r + PTR_ONE;
        end
        case ({push_s, issue_s})
          2'b10:   count_r <= count_r + COUNT_ONE;
          2'b01:   count_r <= count_r - COUNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic        stall_rob_evt_s;
  logic        stall_unit_evt_s;
  logic [31:0] perf_stall_rob_r;
  logic [31:0] perf_stall_unit_r;
  logic [31:0] perf_issued_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      return value + 32'd1;
    end else begin
      return value;
    end
  endfunction

  // Stall classification: ROB stalls take precedence over target-unit stalls.
  always_comb begin
    stall_rob_evt_s  = rdy && !rollback && !empty_s && rob_full;
    stall_unit_evt_s = rdy && !rollback && !empty_s && !rob_full && unit_full_s;
  end

  // Saturating counters; cleared only by reset so they survive rollbacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_rob_r  <= 32'd0;
      perf_stall_unit_r <= 32'd0;
      perf_issued_r     <= 32'd0;
    end else begin
      perf_stall_rob_r  <= sat_inc(perf_stall_rob_r, stall_rob_evt_s);
      perf_stall_unit_r <= sat_inc(perf_stall_unit_r, stall_unit_evt_s);
      perf_issued_r     <= sat_inc(perf_issued_r, issue_s);
    end
  end

  assign perf_stall_rob  = perf_stall_rob_r;
  assign perf_stall_unit = perf_stall_unit_r;
  assign perf_issued     = perf_issued_r;
`endif

endmodule

// File: tb/tb_dispatch_queue_ctrl.sv
// Scoreboard bench for dispatch_queue_ctrl: stimulus queues expected issues,
// a negedge monitor pops and compares every cycle the Decoder is offered an entry.
module tb_dispatch_queue_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  localparam logic [31:0] ALU_INST = 32'h0050_0093;
  localparam logic [31:0] LW_INST  = 32'h0000_2083;
  localparam logic [31:0] ADD_INST = 32'h0020_81b3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        if_predict_jump = 1'b0;
  logic        if_is_c_extend = 1'b0;
  logic        iq_full;
  logic        rob_full = 1'b0;
  logic        rs_full = 1'b0;
  logic        lsb_full = 1'b0;
  logic        dec_inst_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_predict_jump;
  logic        dec_is_c_extend;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_stall_rob;
  logic [31:0] perf_stall_unit;
  logic [31:0] perf_issued;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  dispatch_queue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .rollback         (rollback),
    .if_valid         (if_valid),
    .if_inst          (if_inst),
    .if_pc            (if_pc),
    .if_predict_jump  (if_predict_jump),
    .if_is_c_extend   (if_is_c_extend),
    .iq_full          (iq_full),
    .rob_full         (rob_full),
    .rs_full          (rs_full),
    .lsb_full         (lsb_full),
    .dec_inst_valid   (dec_inst_valid),
    .dec_inst         (dec_inst),
    .dec_pc           (dec_pc),
    .dec_predict_jump (dec_predict_jump),
    .dec_is_c_extend  (dec_is_c_extend)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_stall_rob   (perf_stall_rob),
    .perf_stall_unit  (perf_stall_unit),
    .perf_issued      (perf_issued)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every offered issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dec_inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc 0x%08h, expected no issue", dec_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_pc", dec_pc, e.pc);
        check("issue_inst", dec_inst, e.inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [31:0] inst, input bit accept);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    if (accept) exp_q.push_back('{pc: pc, inst: inst});
  endtask

  task automatic idle();
    if_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    @(negedge clk);
    check("reset_iq_full", 32'(iq_full), 32'd0);
    check("reset_valid", 32'(dec_inst_valid), 32'd0);
    tick();
    rst = 1'b0;

    // Three ALU instructions, each issuing the cycle after its push
    set_push(32'h0, ALU_INST, 1'b1);
    tick();
    set_push(32'h4, ALU_INST, 1'b1);
    @(negedge clk);
    check("alu_valid0", 32'(dec_inst_valid), 32'd1);
    tick();
    set_push(32'h8, ALU_INST, 1'b1);
    @(negedge clk);
    check("alu_valid1", 32'(dec_inst_valid), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("alu_valid2", 32'(dec_inst_valid), 32'd1);
    tick();
    @(negedge clk);
    check("alu_empty_valid", 32'(dec_inst_valid), 32'd0);
    drain("alu_drain", 4);

    // Fill all 16 entries behind a full RS
    rs_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_push(32'h100 + 32'(4 * i), 32'h0000_0093 | (32'(i) << 20), 1'b1);
      tick();
    end
    idle();
    @(negedge clk);
    check("fill_iq_full", 32'(iq_full), 32'd1);
    check("fill_valid", 32'(dec_inst_valid), 32'd0);
    set_push(32'h200, ALU_INST, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("fill_17th_iq_full", 32'(iq_full), 32'd1);
    check("fill_head_pc", dec_pc, 32'h100);
    rs_full = 1'b0;
    set_push(32'h300, ALU_INST, 1'b0);
    tick();
    idle();
    drain("fill_drain", 40);
    @(negedge clk);
    check("fill_after_iq_full", 32'(iq_full), 32'd0);
    check("fill_after_valid", 32'(dec_inst_valid), 32'd0);
    tick();

    // Load blocked on a full LSB holds back the younger add
    lsb_full = 1'b1;
    set_push(32'h400, LW_INST, 1'b1);
    tick();
    set_push(32'h404, ADD_INST, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lsb_block_valid", 32'(dec_inst_valid), 32'd0);
      check("lsb_block_head", dec_pc, 32'h400);
      tick();
    end
    lsb_full = 1'b0;
    drain("lsb_drain", 8);

    // Rollback with five entries queued and a simultaneous push
    rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_push(32'h500 + 32'(4 * i), ALU_INST, 1'b0);
      tick();
    end
    rs_full = 1'b0;
    rollback = 1'b1;
    set_push(32'h600, ALU_INST, 1'b0);
    @(negedge clk);
    check("rollback_cycle_valid", 32'(dec_inst_valid), 32'd0);
    tick();
    rollback = 1'b0;
    idle();
    @(negedge clk);
    check("rollback_after_valid", 32'(dec_inst_valid), 32'd0);
    check("rollback_after_iq_full", 32'(iq_full), 32'd0);
    tick();
    tick();
    set_push(32'h700, ALU_INST, 1'b1);
    tick();
    idle();
    drain("rollback_drain", 6);

    // Pointer wrap: 40 push/pop pairs at occupancy 1, with a 2-cycle freeze
    set_push(32'h1000, ALU_INST, 1'b1);
    tick();
    for (int i = 1; i <= 40; i++) begin
      if (i == 20) begin
        rdy = 1'b0;
        set_push(32'hDEAD_0000, ALU_INST, 1'b0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("freeze_valid", 32'(dec_inst_valid), 32'd0);
          check("freeze_head", dec_pc, 32'h1000 + 32'(4 * 19));
          tick();
        end
        rdy = 1'b1;
      end
      set_push(32'h1000 + 32'(4 * i), ALU_INST, 1'b1);
      tick();
    end
    idle();
    drain("wrap_drain", 6);

    // Reset mid-operation drops queued entries
    rs_full = 1'b1;
    set_push(32'h800, ALU_INST, 1'b0);
    tick();
    set_push(32'h804, ALU_INST, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    rollback = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(dec_inst_valid), 32'd0);
    check("rst_mid_iq_full", 32'(iq_full), 32'd0);
    tick();
    rst = 1'b0;
    rollback = 1'b0;
    rs_full = 1'b0;
    @(negedge clk);
    check("rst_dropped_valid", 32'(dec_inst_valid), 32'd0);
`ifdef DISPATCH_PERF_EN
    check("perf_rst_stall_rob", perf_stall_rob, 32'd0);
    check("perf_rst_stall_unit", perf_stall_unit, 32'd0);
    check("perf_rst_issued", perf_issued, 32'd0);
`endif
    tick();

    // Three ROB-stall cycles, then two issues; then two LSB-stall cycles and one issue
    rob_full = 1'b1;
    set_push(32'h900, ALU_INST, 1'b1);
    tick();
    set_push(32'h904, ALU_INST, 1'b1);
    tick();
    idle();
    tick();
    @(negedge clk);
    check("rob_stall_valid", 32'(dec_inst_valid), 32'd0);
    tick();
    rob_full = 1'b0;
    drain("rob_drain", 6);
    lsb_full = 1'b1;
    set_push(32'h910, LW_INST, 1'b1);
    tick();
    idle();
    tick();
    tick();
    lsb_full = 1'b0;
    drain("unit_drain", 6);
`ifdef DISPATCH_PERF_EN
    check("perf_stall_rob", perf_stall_rob, 32'd3);
    check("perf_stall_unit", perf_stall_unit, 32'd2);
    check("perf_issued", perf_issued, 32'd3);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    tick();
    check("perf_keep_stall_rob", perf_stall_rob, 32'd3);
    check("perf_keep_stall_unit", perf_stall_unit, 32'd2);
    check("perf_keep_issued", perf_issued, 32'd3);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
